// File: rtl/omp_final_stage_ctrl.sv
// Final OMP solve-stage sequencer: launches the b-vector engine, captures and
// validates its b stream, then launches the back-substitution solver.
module omp_final_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int CNT_W          = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dri_mode,
  input  logic [3:0]  final_i,
  output logic        cb_start,
  output logic [4:0]  cb_K_final,
  output logic [2:0]  cb_M_limit,
  input  logic [3:0]  cb_b_idx,
  input  logic [23:0] cb_b_val,
  input  logic        cb_b_we,
  input  logic        cb_done,
  output logic        bs_start,
  input  logic        bs_done,
  input  logic [3:0]  b_rd_addr,
  output logic [23:0] b_rd_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  // state    | meaning
  // IDLE     | waiting for start
  // LAUNCH_B | cb_start pulse, watchdog cleared
  // WAIT_B   | capturing b stream until cb_done or timeout
  // CHECK_B  | validating count and valid bitmap
  // LAUNCH_S | bs_start pulse, watchdog cleared
  // WAIT_S   | waiting for bs_done or timeout
  // FINISH   | done pulse, success
  // ERROR    | done pulse with err/err_code
  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH_B, S_WAIT_B, S_CHECK_B,
    S_LAUNCH_S, S_WAIT_S, S_FINISH, S_ERROR
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] wd_q;
  logic [4:0]       k_q;
  logic [2:0]       m_q;
  logic [4:0]       cnt_q;
  logic [15:0]      valid_q;
  logic             bad_q;
  logic             cb_start_q;
  logic             bs_start_q;
  logic             done_q;
  logic             err_q;
  logic [1:0]       code_q;
  logic [23:0]      b_file_q [16];

  logic        wr_en;
  logic        wr_bad;
  logic [15:0] k_mask;

  assign wr_en  = (state_q == S_WAIT_B) && cb_b_we;
  assign wr_bad = ({1'b0, cb_b_idx} >= k_q) || valid_q[cb_b_idx];

  always_comb begin
    k_mask = '0;
    for (int i = 0; i < 16; i++) begin
      k_mask[i] = (5'(i) < k_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wd_q       <= '0;
      k_q        <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      valid_q    <= '0;
      bad_q      <= 1'b0;
      cb_start_q <= 1'b0;
      bs_start_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= 2'b00;
      for (int i = 0; i < 16; i++) begin
        b_file_q[i] <= '0;
      end
    end else begin
      cb_start_q <= 1'b0;
      bs_start_q <= 1'b0;
      done_q     <= 1'b0;

      // A write in the same cycle as cb_done is still captured before CHECK_B.
      if (wr_en) begin
        b_file_q[cb_b_idx] <= cb_b_val;
        valid_q[cb_b_idx]  <= 1'b1;
        cnt_q              <= cnt_q + 5'd1;
        if (wr_bad) bad_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            k_q        <= {1'b0, final_i} + 5'd1;
            m_q        <= dri_mode ? 3'd7 : 3'd1;
            err_q      <= 1'b0;
            code_q     <= 2'b00;
            valid_q    <= '0;
            cnt_q      <= '0;
            bad_q      <= 1'b0;
            cb_start_q <= 1'b1;
            state_q    <= S_LAUNCH_B;
          end
        end
        S_LAUNCH_B: begin
          wd_q    <= '0;
          state_q <= S_WAIT_B;
        end
        S_WAIT_B: begin
          if (cb_done) begin
            state_q <= S_CHECK_B;
          end else if (wd_q == WD_LAST) begin
            err_q   <= 1'b1;
            code_q  <= 2'b01;
            done_q  <= 1'b1;
            state_q <= S_ERROR;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_CHECK_B: begin
          if (bad_q || (cnt_q != k_q) || ((valid_q & k_mask) != k_mask)) begin
            err_q   <= 1'b1;
            code_q  <= 2'b10;
            done_q  <= 1'b1;
            state_q <= S_ERROR;
          end else begin
            bs_start_q <= 1'b1;
            state_q    <= S_LAUNCH_S;
          end
        end
        S_LAUNCH_S: begin
          wd_q    <= '0;
          state_q <= S_WAIT_S;
        end
        S_WAIT_S: begin
          if (bs_done) begin
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else if (wd_q == WD_LAST) begin
            err_q   <= 1'b1;
            code_q  <= 2'b11;
            done_q  <= 1'b1;
            state_q <= S_ERROR;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_FINISH: state_q <= S_IDLE;
        S_ERROR:  state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign cb_start   = cb_start_q;
  assign bs_start   = bs_start_q;
  assign cb_K_final = k_q;
  assign cb_M_limit = m_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign b_rd_data  = b_file_q[b_rd_addr];

endmodule

// File: doc/omp_final_stage_ctrl.md
# omp_final_stage_ctrl

Sequencer for the final OMP solve stage: launches the b-vector engine (Qᵀy, one 24-bit Q10.13 entry per selected column), captures its write stream into a 16-entry b register file, validates completeness, then launches the back-substitution solver, which reads b from this block. It sits between the top-level OMP iteration FSM and the b-vector/solver datapaths, and provides the watchdog and error reporting for both.

## Interface
Parameters:
- TIMEOUT_CYCLES, 4095, max cycles allowed in each wait state before error
- CNT_W, 12, watchdog counter width (must hold TIMEOUT_CYCLES)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle launch request; sampled only in IDLE
- dri_mode  in  1  0 = 4x4 DRI (M_limit 1), 1 = 8x8 (M_limit 7); sampled at start
- final_i  in  4  last selected atom index; K = final_i+1 (1..16); sampled at start
- cb_start  out  1  one-cycle start pulse to b-vector engine
- cb_K_final  out  5  K, held stable from launch to done
- cb_M_limit  out  3  1 or 7, held stable from launch to done
- cb_b_idx  in  4  b entry index
- cb_b_val  in  24  b entry value (Q10.13)
- cb_b_we  in  1  b entry write strobe (one cycle per entry)
- cb_done  in  1  b-vector engine completion pulse
- bs_start  out  1  one-cycle start pulse to solver
- bs_done  in  1  solver completion pulse
- b_rd_addr  in  4  solver read address
- b_rd_data  out  24  combinational read of b file[b_rd_addr]
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run (success or error)
- err  out  1  error flag; sticky until next accepted start
- err_code  out  2  00 none, 01 b-engine timeout, 10 b stream invalid, 11 solver timeout

## Operation
- States: IDLE, LAUNCH_B, WAIT_B, CHECK_B, LAUNCH_S, WAIT_S, FINISH, ERROR.
- IDLE: on start, latch K/M, clear err/err_code, clear the 16-bit valid bitmap and the write counter (data is retained), then go to LAUNCH_B.
- LAUNCH_B: cb_start=1 for one cycle; clear the watchdog; go to WAIT_B.
- WAIT_B: on each cb_b_we:
  - write b file[cb_b_idx] = cb_b_val;
  - set valid[idx];
  - increment the 5-bit counter;
  - if idx ≥ K or valid[idx] is already set, set the sticky bad flag.
  - cb_done → CHECK_B. The watchdog increments every cycle; reaching TIMEOUT_CYCLES without cb_done → ERROR with code 01.
- cb_b_we in the same cycle as cb_done: the write is accepted and counted before CHECK_B evaluates.
- cb_b_we outside WAIT_B: ignored (no write, no count).
- CHECK_B: if bad, or count ≠ K, or valid[K-1:0] is not all ones → ERROR with code 10; otherwise → LAUNCH_S.
- LAUNCH_S: bs_start=1 for one cycle; clear the watchdog; go to WAIT_S.
- WAIT_S: bs_done → FINISH; timeout → ERROR with code 11. cb_done/cb_b_we arriving here are ignored.
- FINISH: done=1 → IDLE.
- ERROR: err=1, err_code latched, done=1 → IDLE.
- start while busy: ignored, with no effect on the current run.
- b_rd_data is valid in any state; the solver must only read entries 0..K-1.
- Reset mid-operation: the FSM returns to IDLE and all outputs go to reset values. In-flight done pulses from the datapaths are ignored once in IDLE.

## Timing
- Reset values:
  - cb_start, bs_start, busy, done, err = 0; err_code = 00;
  - cb_K_final = 0; cb_M_limit = 0;
  - b file and valid bitmap = 0; b_rd_data therefore reads 0.
- Launch latency: start at cycle t → cb_start high at t+1 and busy high from t+1.
- CHECK_B → LAUNCH_S takes 1 cycle: cb_done at cycle u → bs_start at u+2.
- bs_done at v → done at v+1; busy falls at v+2.
- Error: timeout detected at cycle w → done and err visible at w+1.
- Watchdog: counts from 0 on the cycle after the launch pulse; error when count == TIMEOUT_CYCLES-1 and no done in that cycle. A done arriving on that same cycle wins.
- Expected b-engine runtime is K·(M_limit+5)+1 cycles, at most 193, well inside the default timeout.
- Back-to-back runs: a new start is accepted in the cycle after done, once the FSM is in IDLE.

## Test plan
- Nominal 8x8: dri_mode=1, final_i=9. Model emits idx 0..9 then cb_done → cb_K_final=10, cb_M_limit=7, a single bs_start, done=1, err=0, and b_rd_data matches each written value.
- Same-cycle last write + done (4x4, final_i=0): cb_b_we idx0 and cb_done in one cycle → accepted, count=1, bs_start two cycles later.
- Invalid stream: K=4, indices 0,1,1,3 then cb_done → err=1, err_code=10, no bs_start. A duplicate-free stream of 0,1,2 only also gives code 10.
- Timeouts with TIMEOUT_CYCLES=16: no cb_done → done+err code 01 exactly 17 cycles after cb_start. A valid b stream followed by no bs_done → code 11.
- Start while busy plus back-to-back: a start pulse in WAIT_B is ignored (one cb_start only). A new start the cycle after done clears err and relaunches.
- Reset mid-WAIT_S: assert rst_n=0 → busy, done, and err drop asynchronously. A later bs_done in IDLE produces no done.
